ace_dispatch_gen: RTL and testbench
===================================

Name: ace_dispatch_gen

Overview:
- Parametrised successor dispatch stage. Takes a renamed packet of N_LANES instructions and checks free-entry credits for Issue Queue, Active List and Load-Store Queue.
- Dispatches all-or-nothing, allocates Active List and LSQ indices per lane, and registers the result toward the backend queues.
- Sits between rename and IQ/AL/LSQ write ports.
- Adds two things the fixed 4-wide block lacks: credit tracking with pointer allocation, and flush recovery with a timed quiesce state.

Parameters:
- N_LANES, 4, dispatch width (1..8).
- PREG_W, 7, physical register tag width.
- AL_DEPTH, 64, Active List entries (power of two).
- IQ_DEPTH, 32, Issue Queue entries.
- LSQ_DEPTH, 16, LSQ entries (power of two).
- RECOVER_CYC, 2, cycles in_ready is held low after flush (>=1).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- stall_i  in  1  external backend stall.
- flush_i  in  1  pipeline flush.
- flush_al_tail_i  in  log2(AL_DEPTH)  AL tail restore value.
- flush_lsq_tail_i  in  log2(LSQ_DEPTH)  LSQ tail restore value.
- in_valid_i  in  1  packet valid from rename.
- in_ready_o  out  1  packet accepted this cycle.
- in_lane_vld_i  in  N_LANES  per-lane valid.
- in_rs1_i, in_rs2_i, in_rd_i  in  N_LANES*PREG_W  physical tags.
- in_cls_i  in  N_LANES*2  class: 00 simple, 01 complex, 10 branch, 11 memory.
- al_ret_i  in  log2(N_LANES)+1  AL entries freed this cycle.
- iq_ret_i  in  log2(N_LANES)+1  IQ entries freed this cycle.
- lsq_ret_i  in  log2(N_LANES)+1  LSQ entries freed this cycle.
- disp_vld_o  out  1  registered packet valid.
- disp_lane_vld_o  out  N_LANES  registered lane valid.
- disp_rs1_o, disp_rs2_o, disp_rd_o  out  N_LANES*PREG_W  registered tags.
- disp_cls_o  out  N_LANES*2  registered class.
- disp_al_idx_o  out  N_LANES*log2(AL_DEPTH)  allocated AL index.
- disp_lsq_idx_o  out  N_LANES*log2(LSQ_DEPTH)  allocated LSQ index (memory lanes).
- credit_err_o  out  1  sticky credit-overflow error.

Behaviour:
- Reset: all disp_* outputs 0; credit_err_o 0; credits at AL_DEPTH/IQ_DEPTH/LSQ_DEPTH; AL and LSQ tails 0; FSM = RUN.
- Demand per packet:
  - n_al = n_iq = popcount(lane_vld).
  - n_lsq = popcount(lane_vld & cls==11).
- Accept: in_ready_o = RUN & !stall_i & !flush_i & al_cred>=n_al & iq_cred>=n_iq & lsq_cred>=n_lsq.
  - in_ready_o depends combinationally on packet contents.
  - Credit check uses registered counters only; same-cycle returns are not bypassed.
- Latency: one cycle. On accept, disp_* loads the packet and disp_vld_o=1 the next cycle. Without accept, disp_vld_o=0 next cycle; data is held but don't-care.
- Index allocation:
  - Lane k AL idx = al_tail + (count of valid lanes below k), mod AL_DEPTH.
  - LSQ idx uses the same rule with memory lanes only.
  - Idx fields of non-qualifying lanes are 0.
  - Tails advance by n_al / n_lsq with natural wrap.
- Credit update each cycle: cred_next = cred - consumed + returned.
  - Simultaneous consume and return are both applied.
  - A result above depth clamps to depth and sets credit_err_o. The flag clears only on reset.
- A packet with in_valid_i=1 and lane_vld=0 is accepted, consumes nothing, and emits disp_vld_o=1 with all lanes invalid.
- FSM:
  - RUN -> RECOVER on flush_i.
  - RECOVER counts RECOVER_CYC cycles, then returns to RUN.
  - flush_i during RECOVER restarts the count.
- On flush_i (any state), next cycle:
  - disp_vld_o=0.
  - Credits reset to full depth.
  - Tails loaded from flush_*_tail_i.
  - Returns in the flush cycle are ignored.
- flush_i has priority over accept. reset has priority over everything.

Optional Feature:
- ACE_DISPATCH_PERF_EN defined: adds outputs perf_stall_al_o, perf_stall_iq_o, perf_stall_lsq_o, perf_stall_ext_o, each 32 bits.
  - Saturating counters, cleared by reset.
  - A counter increments when in_valid_i & RUN & !in_ready_o and its cause holds.
  - Priority order: ext (stall_i), al, iq, lsq; exactly one counter increments per cycle.
- Undefined: those ports and the counter logic do not exist.

Decomposition:
- Package ace_dispatch_pkg: class encodings (CLS_SIMPLE/COMPLEX/BRANCH/MEMORY), FSM state enum (ST_RUN, ST_RECOVER), and clog2-derived width localparams.
- One sub-module, ace_dispatch_credit: a parametrised credit counter (depth, consume, return, flush, error). Instantiated three times for AL/IQ/LSQ.

Test Plan:
- Reset then 4 valid simple lanes -> in_ready_o=1; next cycle disp_vld_o=1, AL idx 0,1,2,3; al_cred=60 the following cycle.
- Lanes 1010 with lane1 memory, lane3 simple -> AL idx lane1=0, lane3=1; LSQ idx lane1=0, lane3=0; lsq_cred 16->15.
- Drain IQ credit to 2 (IQ_DEPTH=32, no returns), offer 3 lanes -> in_ready_o=0. Assert iq_ret_i=1 -> no accept that cycle; accept next cycle.
- AL tail at 62, 4-lane packet -> AL idx 62,63,0,1; tail becomes 2.
- flush_i during accept with flush_al_tail_i=10 -> no disp_vld_o; in_ready_o=0 for 2 cycles; credits full; next dispatch AL idx starts at 10.
- Full credits plus al_ret_i=1 -> credit_err_o=1 sticky; al_cred stays 64.

Source files
------------

// File: rtl/ace_dispatch_gen_pkg.sv
// Shared encodings, FSM states and default widths for the dispatch stage.
package ace_dispatch_pkg;

    typedef enum logic [1:0] {
        CLS_SIMPLE  = 2'b00,
        CLS_COMPLEX = 2'b01,
        CLS_BRANCH  = 2'b10,
        CLS_MEMORY  = 2'b11
    } cls_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } state_e;

    localparam int N_LANES_DEF     = 4;
    localparam int PREG_W_DEF      = 7;
    localparam int AL_DEPTH_DEF    = 64;
    localparam int IQ_DEPTH_DEF    = 32;
    localparam int LSQ_DEPTH_DEF   = 16;
    localparam int RECOVER_CYC_DEF = 2;

    localparam int AL_W_DEF  = $clog2(AL_DEPTH_DEF);
    localparam int LSQ_W_DEF = $clog2(LSQ_DEPTH_DEF);
    localparam int RET_W_DEF = $clog2(N_LANES_DEF) + 1;

    // Width of a per-cycle entry count able to hold 0..n.
    function automatic int ret_w(input int n);
        return $clog2(n) + 1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ace_dispatch_gen_if.sv
// Rename-to-dispatch packet and dispatch-to-backend packet bundle.
interface ace_dispatch_gen_if #(
    parameter int N_LANES = 4,
    parameter int PREG_W  = 7,
    parameter int AL_W    = 6,
    parameter int LSQ_W   = 4
);
    logic                        in_valid_i;
    logic                        in_ready_o;
    logic [N_LANES-1:0]          in_lane_vld_i;
    logic [N_LANES*PREG_W-1:0]   in_rs1_i;
    logic [N_LANES*PREG_W-1:0]   in_rs2_i;
    logic [N_LANES*PREG_W-1:0]   in_rd_i;
    logic [N_LANES*2-1:0]        in_cls_i;

    logic                        disp_vld_o;
    logic [N_LANES-1:0]          disp_lane_vld_o;
    logic [N_LANES*PREG_W-1:0]   disp_rs1_o;
    logic [N_LANES*PREG_W-1:0]   disp_rs2_o;
    logic [N_LANES*PREG_W-1:0]   disp_rd_o;
    logic [N_LANES*2-1:0]        disp_cls_o;
    logic [N_LANES*AL_W-1:0]     disp_al_idx_o;
    logic [N_LANES*LSQ_W-1:0]    disp_lsq_idx_o;

    modport master (
        output in_valid_i, in_lane_vld_i, in_rs1_i, in_rs2_i, in_rd_i, in_cls_i,
        input  in_ready_o,
        input  disp_vld_o, disp_lane_vld_o, disp_rs1_o, disp_rs2_o, disp_rd_o,
               disp_cls_o, disp_al_idx_o, disp_lsq_idx_o
    );

    modport slave (
        input  in_valid_i, in_lane_vld_i, in_rs1_i, in_rs2_i, in_rd_i, in_cls_i,
        output in_ready_o,
        output disp_vld_o, disp_lane_vld_o, disp_rs1_o, disp_rs2_o, disp_rd_o,
               disp_cls_o, disp_al_idx_o, disp_lsq_idx_o
    );
endinterface

// File: rtl/ace_dispatch_gen_credit.sv
// Free-entry credit counter: consume/return each cycle, flush refills, overflow clamps and sets a sticky error.
module ace_dispatch_credit #(
    parameter  int DEPTH = 64,
    parameter  int CNT_W = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] i_consume,
    input  logic [CNT_W-1:0] i_return,
    input  logic             i_flush,
    output logic [CW-1:0]    o_cred,
    output logic             o_err
);
    localparam int SW = CW + CNT_W + 1;

    logic [CW-1:0] r_cred;
    logic          r_err;
    logic [SW-1:0] w_sum;

    assign w_sum = SW'(r_cred) - SW'(i_consume) + SW'(i_return);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cred <= CW'(DEPTH);
            r_err  <= 1'b0;
        end else if (i_flush) begin
            r_cred <= CW'(DEPTH);
        end else if (w_sum > SW'(DEPTH)) begin
            r_cred <= CW'(DEPTH);
            r_err  <= 1'b1;
        end else begin
            r_cred <= CW'(w_sum);
        end
    end

    assign o_cred = r_cred;
    assign o_err  = r_err;
endmodule

// File: rtl/ace_dispatch_gen.sv
// All-or-nothing dispatch with AL/IQ/LSQ credit checks, index allocation and flush recovery.
// Optional stall-cause counters when ACE_DISPATCH_PERF_EN is defined.
module ace_dispatch_gen
    import ace_dispatch_pkg::*;
#(
    parameter  int N_LANES     = N_LANES_DEF,
    parameter  int PREG_W      = PREG_W_DEF,
    parameter  int AL_DEPTH    = AL_DEPTH_DEF,
    parameter  int IQ_DEPTH    = IQ_DEPTH_DEF,
    parameter  int LSQ_DEPTH   = LSQ_DEPTH_DEF,
    parameter  int RECOVER_CYC = RECOVER_CYC_DEF,
    localparam int AL_W        = $clog2(AL_DEPTH),
    localparam int LSQ_W       = $clog2(LSQ_DEPTH),
    localparam int RET_W       = ret_w(N_LANES)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [AL_W-1:0]  flush_al_tail_i,
    input  logic [LSQ_W-1:0] flush_lsq_tail_i,
    ace_dispatch_gen_if.slave bus,
    input  logic [RET_W-1:0] al_ret_i,
    input  logic [RET_W-1:0] iq_ret_i,
    input  logic [RET_W-1:0] lsq_ret_i,
    output logic             credit_err_o
`ifdef ACE_DISPATCH_PERF_EN
    ,
    output logic [31:0]      perf_stall_al_o,
    output logic [31:0]      perf_stall_iq_o,
    output logic [31:0]      perf_stall_lsq_o,
    output logic [31:0]      perf_stall_ext_o
`endif
);
    localparam int AL_CW  = $clog2(AL_DEPTH + 1);
    localparam int IQ_CW  = $clog2(IQ_DEPTH + 1);
    localparam int LSQ_CW = $clog2(LSQ_DEPTH + 1);
    localparam int RC_W   = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

    logic [N_LANES-1:0]     w_mem_vld;
    logic [RET_W-1:0]       w_al_pre  [N_LANES];
    logic [RET_W-1:0]       w_lsq_pre [N_LANES];
    logic [RET_W-1:0]       w_n_al, w_n_lsq;
    logic [AL_CW-1:0]       w_al_cred;
    logic [IQ_CW-1:0]       w_iq_cred;
    logic [LSQ_CW-1:0]      w_lsq_cred;
    logic                   w_al_err, w_iq_err, w_lsq_err;
    logic                   w_al_ok, w_iq_ok, w_lsq_ok;
    logic                   w_ready, w_accept;
    logic [RET_W-1:0]       w_al_use, w_lsq_use;
    logic [N_LANES*AL_W-1:0]  w_al_idx;
    logic [N_LANES*LSQ_W-1:0] w_lsq_idx;

    state_e                 r_state;
    logic [RC_W-1:0]        r_rec_cnt;
    logic [AL_W-1:0]        r_al_tail;
    logic [LSQ_W-1:0]       r_lsq_tail;

    logic                        r_disp_vld;
    logic [N_LANES-1:0]          r_lane_vld;
    logic [N_LANES*PREG_W-1:0]   r_rs1, r_rs2, r_rd;
    logic [N_LANES*2-1:0]        r_cls;
    logic [N_LANES*AL_W-1:0]     r_al_idx;
    logic [N_LANES*LSQ_W-1:0]    r_lsq_idx;

    genvar gi;
    generate
        for (gi = 0; gi < N_LANES; gi++) begin : g_lane
            assign w_mem_vld[gi] = bus.in_lane_vld_i[gi] & (bus.in_cls_i[2*gi +: 2] == CLS_MEMORY);
            assign w_al_idx[gi*AL_W +: AL_W] =
                bus.in_lane_vld_i[gi] ? r_al_tail + AL_W'(w_al_pre[gi]) : '0;
            assign w_lsq_idx[gi*LSQ_W +: LSQ_W] =
                w_mem_vld[gi] ? r_lsq_tail + LSQ_W'(w_lsq_pre[gi]) : '0;
        end
    endgenerate

    // Exclusive prefix counts give each lane its offset from the tail; the totals are the demand.
    always_comb begin
        w_n_al  = '0;
        w_n_lsq = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_al_pre[k]  = w_n_al;
            w_lsq_pre[k] = w_n_lsq;
            w_n_al       = w_n_al + RET_W'(bus.in_lane_vld_i[k]);
            w_n_lsq      = w_n_lsq + RET_W'(w_mem_vld[k]);
        end
    end

    assign w_al_ok  = 32'(w_al_cred)  >= 32'(w_n_al);
    assign w_iq_ok  = 32'(w_iq_cred)  >= 32'(w_n_al);
    assign w_lsq_ok = 32'(w_lsq_cred) >= 32'(w_n_lsq);
    assign w_ready  = (r_state == ST_RUN) & ~stall_i & ~flush_i & w_al_ok & w_iq_ok & w_lsq_ok;
    assign w_accept = bus.in_valid_i & w_ready;
    assign w_al_use  = w_accept ? w_n_al  : '0;
    assign w_lsq_use = w_accept ? w_n_lsq : '0;

    ace_dispatch_credit #(.DEPTH(AL_DEPTH), .CNT_W(RET_W)) u_al_cred (
        .clock(clock), .reset(reset), .i_consume(w_al_use), .i_return(al_ret_i),
        .i_flush(flush_i), .o_cred(w_al_cred), .o_err(w_al_err)
    );
    ace_dispatch_credit #(.DEPTH(IQ_DEPTH), .CNT_W(RET_W)) u_iq_cred (
        .clock(clock), .reset(reset), .i_consume(w_al_use), .i_return(iq_ret_i),
        .i_flush(flush_i), .o_cred(w_iq_cred), .o_err(w_iq_err)
    );
    ace_dispatch_credit #(.DEPTH(LSQ_DEPTH), .CNT_W(RET_W)) u_lsq_cred (
        .clock(clock), .reset(reset), .i_consume(w_lsq_use), .i_return(lsq_ret_i),
        .i_flush(flush_i), .o_cred(w_lsq_cred), .o_err(w_lsq_err)
    );

    // Flush re-enters RECOVER and restarts the quiesce count from either state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_rec_cnt <= '0;
        end else if (flush_i) begin
            r_state   <= ST_RECOVER;
            r_rec_cnt <= '0;
        end else begin
            case (r_state)
                ST_RECOVER: begin
                    if (r_rec_cnt == RC_W'(RECOVER_CYC - 1)) begin
                        r_state   <= ST_RUN;
                        r_rec_cnt <= '0;
                    end else begin
                        r_rec_cnt <= r_rec_cnt + RC_W'(1);
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_al_tail  <= '0;
            r_lsq_tail <= '0;
        end else if (flush_i) begin
            r_al_tail  <= flush_al_tail_i;
            r_lsq_tail <= flush_lsq_tail_i;
        end else if (w_accept) begin
            r_al_tail  <= r_al_tail + AL_W'(w_n_al);
            r_lsq_tail <= r_lsq_tail + LSQ_W'(w_n_lsq);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_disp_vld <= 1'b0;
            r_lane_vld <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_cls      <= '0;
            r_al_idx   <= '0;
            r_lsq_idx  <= '0;
        end else begin
            r_disp_vld <= w_accept;
            if (w_accept) begin
                r_lane_vld <= bus.in_lane_vld_i;
                r_rs1      <= bus.in_rs1_i;
                r_rs2      <= bus.in_rs2_i;
                r_rd       <= bus.in_rd_i;
                r_cls      <= bus.in_cls_i;
                r_al_idx   <= w_al_idx;
                r_lsq_idx  <= w_lsq_idx;
            end
        end
    end

    assign bus.in_ready_o      = w_ready;
    assign bus.disp_vld_o      = r_disp_vld;
    assign bus.disp_lane_vld_o = r_lane_vld;
    assign bus.disp_rs1_o      = r_rs1;
    assign bus.disp_rs2_o      = r_rs2;
    assign bus.disp_rd_o       = r_rd;
    assign bus.disp_cls_o      = r_cls;
    assign bus.disp_al_idx_o   = r_al_idx;
    assign bus.disp_lsq_idx_o  = r_lsq_idx;
    assign credit_err_o        = w_al_err | w_iq_err | w_lsq_err;

`ifdef ACE_DISPATCH_PERF_EN
    logic [31:0] r_perf_al, r_perf_iq, r_perf_lsq, r_perf_ext;

    // One cause is charged per blocked cycle, external stall first.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_al  <= '0;
            r_perf_iq  <= '0;
            r_perf_lsq <= '0;
            r_perf_ext <= '0;
        end else if (bus.in_valid_i && r_state == ST_RUN && !w_ready) begin
            if (stall_i)        r_perf_ext <= sat_inc32(r_perf_ext);
            else if (!w_al_ok)  r_perf_al  <= sat_inc32(r_perf_al);
            else if (!w_iq_ok)  r_perf_iq  <= sat_inc32(r_perf_iq);
            else if (!w_lsq_ok) r_perf_lsq <= sat_inc32(r_perf_lsq);
        end
    end

    assign perf_stall_al_o  = r_perf_al;
    assign perf_stall_iq_o  = r_perf_iq;
    assign perf_stall_lsq_o = r_perf_lsq;
    assign perf_stall_ext_o = r_perf_ext;
`endif
endmodule

// File: tb/tb_ace_dispatch_gen.sv
// Directed bench for ace_dispatch_gen at default parameters.
module tb_ace_dispatch_gen;
    import ace_dispatch_pkg::*;

    localparam int NL = 4;
    localparam int PW = 7;
    localparam int AW = AL_W_DEF;
    localparam int LW = LSQ_W_DEF;
    localparam int RW = RET_W_DEF;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall_i;
    logic          flush_i;
    logic [AW-1:0] flush_al_tail_i;
    logic [LW-1:0] flush_lsq_tail_i;
    logic [RW-1:0] al_ret_i, iq_ret_i, lsq_ret_i;
    logic          credit_err_o;
`ifdef ACE_DISPATCH_PERF_EN
    logic [31:0]   perf_al, perf_iq, perf_lsq, perf_ext;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ace_dispatch_gen_if #(.N_LANES(NL), .PREG_W(PW), .AL_W(AW), .LSQ_W(LW)) u_if ();

    ace_dispatch_gen #(
        .N_LANES(NL), .PREG_W(PW), .AL_DEPTH(64), .IQ_DEPTH(32),
        .LSQ_DEPTH(16), .RECOVER_CYC(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .stall_i(stall_i),
        .flush_i(flush_i),
        .flush_al_tail_i(flush_al_tail_i),
        .flush_lsq_tail_i(flush_lsq_tail_i),
        .bus(u_if),
        .al_ret_i(al_ret_i),
        .iq_ret_i(iq_ret_i),
        .lsq_ret_i(lsq_ret_i),
        .credit_err_o(credit_err_o)
`ifdef ACE_DISPATCH_PERF_EN
        ,
        .perf_stall_al_o(perf_al),
        .perf_stall_iq_o(perf_iq),
        .perf_stall_lsq_o(perf_lsq),
        .perf_stall_ext_o(perf_ext)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pkt(input logic v, input logic [NL-1:0] lv, input logic [2*NL-1:0] cls);
        u_if.in_valid_i    = v;
        u_if.in_lane_vld_i = lv;
        u_if.in_cls_i      = cls;
        u_if.in_rs1_i      = {7'd4, 7'd3, 7'd2, 7'd1};
        u_if.in_rs2_i      = {7'd8, 7'd7, 7'd6, 7'd5};
        u_if.in_rd_i       = {7'd44, 7'd33, 7'd22, 7'd11};
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        stall_i          = 1'b0;
        flush_i          = 1'b0;
        flush_al_tail_i  = '0;
        flush_lsq_tail_i = '0;
        al_ret_i         = '0;
        iq_ret_i         = '0;
        lsq_ret_i        = '0;
        pkt(1'b0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_disp_vld", u_if.disp_vld_o, 0);
        chk("rst_al_idx", u_if.disp_al_idx_o, 0);
        chk("rst_err", credit_err_o, 0);
        chk("rst_al_cred", dut.w_al_cred, 64);
        chk("rst_ready", u_if.in_ready_o, 1);
        $display("txn reset: checked");

        // Four simple lanes after reset
        pkt(1'b1, 4'b1111, 8'h00);
        #1;
        chk("s1_ready", u_if.in_ready_o, 1);
        tick();
        pkt(1'b0, '0, '0);
        chk("s1_disp_vld", u_if.disp_vld_o, 1);
        chk("s1_al_idx", u_if.disp_al_idx_o, {6'd3, 6'd2, 6'd1, 6'd0});
        chk("s1_rd", u_if.disp_rd_o, {7'd44, 7'd33, 7'd22, 7'd11});
        chk("s1_al_cred", dut.w_al_cred, 60);
        chk("s1_iq_cred", dut.w_iq_cred, 28);
        tick();
        chk("s1_idle_vld", u_if.disp_vld_o, 0);
        $display("txn 4-lane simple: dispatched");

        // Empty packet still dispatches
        pkt(1'b1, 4'b0000, 8'h00);
        #1;
        chk("empty_ready", u_if.in_ready_o, 1);
        tick();
        pkt(1'b0, '0, '0);
        chk("empty_vld", u_if.disp_vld_o, 1);
        chk("empty_lanes", u_if.disp_lane_vld_o, 0);
        chk("empty_al_cred", dut.w_al_cred, 60);
        $display("txn empty packet: dispatched");

        // External stall blocks
        stall_i = 1'b1;
        pkt(1'b1, 4'b1111, 8'h00);
        #1;
        chk("stall_ready", u_if.in_ready_o, 0);
        tick();
        stall_i = 1'b0;
        pkt(1'b0, '0, '0);
        chk("stall_vld", u_if.disp_vld_o, 0);
        $display("txn stall: blocked");

        // Mixed memory / simple lanes
        do_reset();
        pkt(1'b1, 4'b1010, 8'b0000_1100);
        #1;
        chk("s2_ready", u_if.in_ready_o, 1);
        tick();
        pkt(1'b1, 4'b0001, 8'b0000_0011);
        chk("s2_al_idx", u_if.disp_al_idx_o, {6'd1, 6'd0, 6'd0, 6'd0});
        chk("s2_lsq_idx", u_if.disp_lsq_idx_o, 0);
        chk("s2_cls", u_if.disp_cls_o, 8'b0000_1100);
        chk("s2_lsq_cred", dut.w_lsq_cred, 15);
        tick();
        pkt(1'b0, '0, '0);
        chk("s2b_al_idx", u_if.disp_al_idx_o, {6'd0, 6'd0, 6'd0, 6'd2});
        chk("s2b_lsq_idx", u_if.disp_lsq_idx_o, {4'd0, 4'd0, 4'd0, 4'd1});
        chk("s2b_lsq_cred", dut.w_lsq_cred, 14);
        $display("txn memory lanes: dispatched");

        // IQ credit exhaustion, return not bypassed
        do_reset();
        for (int i = 0; i < 7; i++) begin
            pkt(1'b1, 4'b1111, 8'h00);
            tick();
        end
        pkt(1'b1, 4'b0011, 8'h00);
        tick();
        chk("s3_iq_cred", dut.w_iq_cred, 2);
        pkt(1'b1, 4'b0111, 8'h00);
        #1;
        chk("s3_ready_short", u_if.in_ready_o, 0);
        iq_ret_i = 3'd1;
        #1;
        chk("s3_ready_nobypass", u_if.in_ready_o, 0);
        tick();
        iq_ret_i = '0;
        chk("s3_blocked_vld", u_if.disp_vld_o, 0);
        chk("s3_iq_ret", dut.w_iq_cred, 3);
        #1;
        chk("s3_ready_after", u_if.in_ready_o, 1);
        tick();
        pkt(1'b0, '0, '0);
        chk("s3_disp_vld", u_if.disp_vld_o, 1);
        chk("s3_iq_zero", dut.w_iq_cred, 0);
        chk("s3_al_idx", u_if.disp_al_idx_o, {6'd0, 6'd32, 6'd31, 6'd30});
        $display("txn iq credit: blocked then dispatched");

        // AL tail wrap
        do_reset();
        al_ret_i = 3'd4;
        iq_ret_i = 3'd4;
        for (int i = 0; i < 15; i++) begin
            pkt(1'b1, 4'b1111, 8'h00);
            tick();
        end
        al_ret_i = 3'd2;
        iq_ret_i = 3'd2;
        pkt(1'b1, 4'b0011, 8'h00);
        tick();
        al_ret_i = '0;
        iq_ret_i = '0;
        chk("s4_al_cred", dut.w_al_cred, 64);
        pkt(1'b1, 4'b1111, 8'h00);
        #1;
        chk("s4_ready", u_if.in_ready_o, 1);
        tick();
        pkt(1'b1, 4'b0001, 8'h00);
        chk("s4_wrap_idx", u_if.disp_al_idx_o, {6'd1, 6'd0, 6'd63, 6'd62});
        tick();
        pkt(1'b0, '0, '0);
        chk("s4_tail2", u_if.disp_al_idx_o, {6'd0, 6'd0, 6'd0, 6'd2});
        chk("s4_err", credit_err_o, 0);
        $display("txn al wrap: dispatched");

        // Flush during an acceptable packet
        do_reset();
        pkt(1'b1, 4'b1111, 8'h00);
        tick();
        flush_i         = 1'b1;
        flush_al_tail_i = 6'd10;
        al_ret_i        = 3'd1;
        #1;
        chk("s5_ready_flush", u_if.in_ready_o, 0);
        tick();
        flush_i  = 1'b0;
        al_ret_i = '0;
        chk("s5_vld_flush", u_if.disp_vld_o, 0);
        chk("s5_al_cred", dut.w_al_cred, 64);
        chk("s5_iq_cred", dut.w_iq_cred, 32);
        #1;
        chk("s5_ready_rec1", u_if.in_ready_o, 0);
        tick();
        chk("s5_vld_rec", u_if.disp_vld_o, 0);
        chk("s5_ready_rec2", u_if.in_ready_o, 0);
        tick();
        chk("s5_ready_run", u_if.in_ready_o, 1);
        tick();
        pkt(1'b0, '0, '0);
        chk("s5_disp_vld", u_if.disp_vld_o, 1);
        chk("s5_al_idx", u_if.disp_al_idx_o, {6'd13, 6'd12, 6'd11, 6'd10});
        chk("s5_err", credit_err_o, 0);
        $display("txn flush: recovered");

        // Credit overflow is sticky
        do_reset();
        al_ret_i = 3'd1;
        tick();
        al_ret_i = '0;
        chk("s6_err", credit_err_o, 1);
        chk("s6_al_cred", dut.w_al_cred, 64);
        tick();
        chk("s6_err_sticky", credit_err_o, 1);
        $display("txn credit overflow: flagged");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
